emulib_rammodel_encoder_r_wide: RTL

EMULIB_RAMMODEL_ENCODER_R_WIDE -- requirements
Module: emulib_rammodel_encoder_r_wide

---
 rtl/emulib_rammodel_encoder_r_wide.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/emulib_rammodel_encoder_r_wide.sv
// AXI R-channel beat encoder: buffers R beats and serialises each one as a header word followed by NW data words.
// Optional trailing XOR checksum word when EMULIB_RAMMODEL_ENCODER_CHECKSUM_EN is defined.
module emulib_rammodel_encoder_r_wide #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 128,
   parameter int ID_WIDTH   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  axi_rvalid,
   output logic                  axi_rready,
   input  logic [DATA_WIDTH-1:0] axi_rdata,
   input  logic [1:0]            axi_rresp,
   input  logic [ID_WIDTH-1:0]   axi_rid,
   input  logic                  axi_rlast,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic [31:0]           data,
   output logic                  idle
);
   localparam int NW = DATA_WIDTH / 32;
   localparam int IW = (NW > 1) ? $clog2(NW) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = ID_WIDTH + 3 + DATA_WIDTH;

`ifdef EMULIB_RAMMODEL_ENCODER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE = 2'd0, HEAD = 2'd1, DATA = 2'd2, CSUM = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, HEAD = 2'd1, DATA = 2'd2} state_t;
`endif

   state_t                state, state_nx;
   logic [EW-1:0]         mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [PW:0]           count;
   logic [DATA_WIDTH-1:0] cur_data;
   logic [IW-1:0]         idx, idx_nx, word_sel;
   logic                  push, pop, fire, load_hdr, load_word;
   logic                  fifo_empty, fifo_full;
   logic [EW-1:0]         head;
   logic [31:0]           hdr_word, sel_word;
`ifdef EMULIB_RAMMODEL_ENCODER_CHECKSUM_EN
   logic [31:0]           csum;
   logic                  load_csum;
`endif

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
   assign axi_rready = !fifo_full;
   assign push       = axi_rvalid && axi_rready;
   assign data_valid = (state != IDLE);
   assign fire       = data_valid && data_ready;
   assign idle       = (state == IDLE) && fifo_empty;
   assign head       = mem[rd_ptr];
   assign hdr_word   = {16'(head[EW-1 -: ID_WIDTH]), 13'd0,
                        head[DATA_WIDTH+2 -: 2], head[DATA_WIDTH]};
   assign sel_word   = cur_data[word_sel*32 +: 32];

   // Beat storage; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {axi_rid, axi_rresp, axi_rlast, axi_rdata};
      end
   end

   // Next-state and serialiser control.
   always_comb begin
      state_nx  = state;
      pop       = 1'b0;
      load_hdr  = 1'b0;
      load_word = 1'b0;
      idx_nx    = idx;
      word_sel  = idx;
`ifdef EMULIB_RAMMODEL_ENCODER_CHECKSUM_EN
      load_csum = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               load_hdr = 1'b1;
               state_nx = HEAD;
            end else begin
               state_nx = IDLE;
            end
         end
         HEAD: begin
            if (fire) begin
               load_word = 1'b1;
               word_sel  = '0;
               idx_nx    = '0;
               state_nx  = DATA;
            end else begin
               state_nx  = HEAD;
            end
         end
         DATA: begin
            if (fire && (idx == IW'(NW-1))) begin
`ifdef EMULIB_RAMMODEL_ENCODER_CHECKSUM_EN
               load_csum = 1'b1;
               state_nx  = CSUM;
`else
               // Chain straight into the next header so consecutive beats leave no bubble.
               pop       = !fifo_empty;
               load_hdr  = !fifo_empty;
               state_nx  = fifo_empty ? IDLE : HEAD;
`endif
            end else if (fire) begin
               load_word = 1'b1;
               word_sel  = idx + 1'b1;
               idx_nx    = idx + 1'b1;
            end else begin
               state_nx  = DATA;
            end
         end
`ifdef EMULIB_RAMMODEL_ENCODER_CHECKSUM_EN
         CSUM: begin
            if (fire) begin
               pop      = !fifo_empty;
               load_hdr = !fifo_empty;
               state_nx = fifo_empty ? IDLE : HEAD;
            end else begin
               state_nx = CSUM;
            end
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   // State, FIFO pointers and output word register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         idx      <= '0;
         data     <= 32'd0;
         cur_data <= '0;
`ifdef EMULIB_RAMMODEL_ENCODER_CHECKSUM_EN
         csum     <= 32'd0;
`endif
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            cur_data <= head[DATA_WIDTH-1:0];
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (load_hdr) begin
            data <= hdr_word;
`ifdef EMULIB_RAMMODEL_ENCODER_CHECKSUM_EN
            csum <= hdr_word;
`endif
         end else if (load_word) begin
            data <= sel_word;
`ifdef EMULIB_RAMMODEL_ENCODER_CHECKSUM_EN
            csum <= csum ^ sel_word;
`endif
         end
`ifdef EMULIB_RAMMODEL_ENCODER_CHECKSUM_EN
         else if (load_csum) begin
            data <= csum;
         end
`endif
      end
   end
endmodule
